ldst_load_response_scatter: RTL and testbench

Downstream neighbour of the memory command coalesce buffer in the CGRA ld/st unit. It accepts one coalesced load response per handshake: a full cache line plus the tid bitmap and per-thread address map captured at coalesce time. It scatters the response into per-thread register writebacks, one thread per cycle, and buffers up to FIFO_DEPTH responses so the memory side is not stalled by writeback backpressure.

---
 rtl/ldst_load_response_scatter_if.sv | 37 +++
 rtl/ldst_load_response_scatter.sv | 145 ++++++++++++++
 tb/tb_ldst_load_response_scatter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldst_load_response_scatter_if.sv
// Handshake bundle between the coalesce buffer, the load response scatter
// stage and the register writeback consumer.
interface ldst_load_response_scatter_if #(
   parameter int CACHE_LINE_SIZE = 32,
   parameter int MAX_COALESCED   = 8,
   parameter int OFFSET_W        = $clog2(CACHE_LINE_SIZE)
);
   logic                                rsp_valid;
   logic                                rsp_ready;
   logic [3:0]                          rsp_block_id;
   logic [9:0]                          rsp_base_tid;
   logic [MAX_COALESCED-1:0]            rsp_tid_bitmap;
   logic [1:0]                          rsp_size;
   logic [6:0]                          rsp_ld_dest_reg;
   logic [CACHE_LINE_SIZE*8-1:0]        rsp_data;
   logic [MAX_COALESCED*OFFSET_W-1:0]   rsp_address_map;

   logic                                wb_valid;
   logic                                wb_ready;
   logic [3:0]                          wb_block_id;
   logic [9:0]                          wb_tid;
   logic [6:0]                          wb_dest_reg;
   logic [63:0]                         wb_data;
   logic                                wb_last;

   modport slave (
      input  rsp_valid, rsp_block_id, rsp_base_tid, rsp_tid_bitmap, rsp_size,
             rsp_ld_dest_reg, rsp_data, rsp_address_map, wb_ready,
      output rsp_ready, wb_valid, wb_block_id, wb_tid, wb_dest_reg, wb_data, wb_last
   );

   modport master (
      output rsp_valid, rsp_block_id, rsp_base_tid, rsp_tid_bitmap, rsp_size,
             rsp_ld_dest_reg, rsp_data, rsp_address_map, wb_ready,
      input  rsp_ready, wb_valid, wb_block_id, wb_tid, wb_dest_reg, wb_data, wb_last
   );
endinterface

// File: rtl/ldst_load_response_scatter.sv
// Buffers coalesced load responses and scatters each one into per-thread
// register writebacks, lowest pending thread first, one thread per cycle.
module ldst_load_response_scatter #(
   parameter int CACHE_LINE_SIZE = 32,
   parameter int MAX_COALESCED   = 8,
   parameter int OFFSET_W        = $clog2(CACHE_LINE_SIZE),
   parameter int TID_OFF_W       = $clog2(MAX_COALESCED),
   parameter int FIFO_DEPTH      = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   ldst_load_response_scatter_if.slave  bus,
   output logic                         busy
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int LINE_W = CACHE_LINE_SIZE * 8;
   localparam int MAP_W  = MAX_COALESCED * OFFSET_W;

   typedef struct packed {
      logic [3:0]               block_id;
      logic [9:0]               base_tid;
      logic [MAX_COALESCED-1:0] pending;
      logic [1:0]               size;
      logic [6:0]               dest_reg;
      logic [LINE_W-1:0]        data;
      logic [MAP_W-1:0]         address_map;
   } entry_t;

   entry_t                   entry_q [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]         count_q, count_d;

   entry_t                   head;
   logic                     head_valid;
   logic [TID_OFF_W-1:0]     idx;
   logic                     found;
   logic                     last;
   logic [OFFSET_W-1:0]      off;
   logic [3:0]               nbytes;
   logic [OFFSET_W:0]        pos;
   logic [63:0]              extract;
   logic [MAX_COALESCED-1:0] clear_mask;
   logic                     accept, push, retire, pop;

   assign head       = entry_q[rd_ptr_q];
   assign head_valid = (count_q != '0);
   assign busy       = head_valid;

   // Backpressure looks at occupancy only, so a full FIFO never takes a
   // response in the same cycle its head pops.
   assign bus.rsp_ready = (count_q < CNT_W'(FIFO_DEPTH));

   assign accept = bus.rsp_valid && bus.rsp_ready;
   assign push   = accept && (bus.rsp_tid_bitmap != '0);
   assign retire = head_valid && bus.wb_ready;
   assign pop    = retire && last;

   // NOTE: every variable driven here gets a default before any branch, so no latch is inferred.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_COALESCED; i++) begin
         if (!found && head.pending[i]) begin
            idx   = TID_OFF_W'(i);
            found = 1'b1;
         end
      end
   end

   assign last       = ((head.pending & (head.pending - MAX_COALESCED'(1))) == '0);
   assign clear_mask = MAX_COALESCED'(1) << idx;

   // Bytes past the end of the line read as zero instead of wrapping.
   always_comb begin
      off     = head.address_map[idx*OFFSET_W +: OFFSET_W];
      nbytes  = 4'd1 << head.size;
      extract = '0;
      pos     = '0;
      for (int j = 0; j < 8; j++) begin
         pos = {1'b0, off} + (OFFSET_W+1)'(j);
         if ((j < int'(nbytes)) && (pos < (OFFSET_W+1)'(CACHE_LINE_SIZE))) begin
            extract[j*8 +: 8] = head.data[pos*8 +: 8];
         end
      end
   end

   always_comb begin
      bus.wb_valid    = head_valid;
      bus.wb_block_id = '0;
      bus.wb_tid      = '0;
      bus.wb_dest_reg = '0;
      bus.wb_data     = '0;
      bus.wb_last     = 1'b0;
      if (head_valid) begin
         bus.wb_block_id = head.block_id;
         bus.wb_tid      = head.base_tid | 10'(idx);
         bus.wb_dest_reg = head.dest_reg;
         bus.wb_data     = extract;
         bus.wb_last     = last;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: entry storage is reset too, so a reset drops every buffered response cleanly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) entry_q[i] <= '0;
      end else begin
         if (retire) entry_q[rd_ptr_q].pending <= head.pending & ~clear_mask;
         if (push) begin
            entry_q[wr_ptr_q] <= '{
               block_id:    bus.rsp_block_id,
               base_tid:    bus.rsp_base_tid,
               pending:     bus.rsp_tid_bitmap,
               size:        bus.rsp_size,
               dest_reg:    bus.rsp_ld_dest_reg,
               data:        bus.rsp_data,
               address_map: bus.rsp_address_map
            };
         end
      end
   end
endmodule

// File: tb/tb_ldst_load_response_scatter.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and a randomized run against a queue-based reference model.
module tb_ldst_load_response_scatter;
   logic clk;
   logic rst_n;
   logic busy;
   int   total;
   int   bad;

   ldst_load_response_scatter_if bus ();

   ldst_load_response_scatter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   blk;
      logic [9:0]   base;
      logic [7:0]   pend;
      logic [1:0]   size;
      logic [6:0]   dst;
      logic [255:0] line;
      logic [39:0]  amap;
   } m_rsp_t;

   typedef struct {
      bit          plus_one;
      logic [1:0]  size;
      int          bit_i;
      logic [4:0]  off;
      logic [9:0]  base;
      logic [9:0]  exp_tid;
      logic [63:0] exp_data;
   } vec_t;

   m_rsp_t mq[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] mk_line(input bit plus_one);
      logic [255:0] l;
      for (int k = 0; k < 32; k++) l[k*8 +: 8] = 8'(k + (plus_one ? 1 : 0));
      return l;
   endfunction

   function automatic logic [39:0] set_map(input logic [39:0] m, input int i, input logic [4:0] v);
      logic [39:0] r;
      r = m;
      r[i*5 +: 5] = v;
      return r;
   endfunction

   // Reference: lowest pending thread, byte-wise copy from the line, zero beyond it.
   task automatic exp_beat(input m_rsp_t r, output logic [9:0] tid,
                           output logic [63:0] data, output logic lst);
      int idx;
      int off;
      int nb;
      idx = 0;
      for (int i = 7; i >= 0; i--) if (r.pend[i]) idx = i;
      tid  = r.base | 10'(idx);
      off  = int'(r.amap[idx*5 +: 5]);
      nb   = 1 << r.size;
      data = '0;
      for (int j = 0; j < nb; j++)
         if (off + j < 32) data[j*8 +: 8] = r.line[(off+j)*8 +: 8];
      lst = ($countones(r.pend) == 1);
   endtask

   task automatic idle_inputs();
      bus.rsp_valid       = 1'b0;
      bus.rsp_block_id    = '0;
      bus.rsp_base_tid    = '0;
      bus.rsp_tid_bitmap  = '0;
      bus.rsp_size        = '0;
      bus.rsp_ld_dest_reg = '0;
      bus.rsp_data        = '0;
      bus.rsp_address_map = '0;
   endtask

   task automatic set_rsp(input m_rsp_t r);
      bus.rsp_block_id    = r.blk;
      bus.rsp_base_tid    = r.base;
      bus.rsp_tid_bitmap  = r.pend;
      bus.rsp_size        = r.size;
      bus.rsp_ld_dest_reg = r.dst;
      bus.rsp_data        = r.line;
      bus.rsp_address_map = r.amap;
   endtask

   // Starts and ends 1 time unit after a rising edge; bounded wait for rsp_ready.
   task automatic send_rsp(input m_rsp_t r);
      logic ok;
      ok = 1'b0;
      set_rsp(r);
      bus.rsp_valid = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         ok = bus.rsp_ready;
         @(posedge clk);
         #1;
         if (ok) break;
      end
      bus.rsp_valid = 1'b0;
      check("send_accepted", 64'(ok), 64'd1);
   endtask

   task automatic do_reset();
      idle_inputs();
      bus.wb_ready = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mq.delete();
   endtask

   initial begin
      vec_t        vecs[8];
      m_rsp_t      r;
      logic [9:0]  etid;
      logic [63:0] edata;
      logic        elast;
      logic        exp_ready, exp_valid, acc, ret;
      logic [7:0]  bm;

      total = 0;
      bad   = 0;

      // Test-plan vectors; data values derived by hand from the line pattern.
      vecs[0] = '{0, 2'b10, 0,  5'd4,  10'h040, 10'h040, 64'h0000_0000_0706_0504};
      vecs[1] = '{0, 2'b10, 2,  5'd8,  10'h040, 10'h042, 64'h0000_0000_0B0A_0908};
      vecs[2] = '{1, 2'b11, 7,  5'd29, 10'h100, 10'h107, 64'h0000_0000_0020_1F1E};
      vecs[3] = '{0, 2'b00, 3,  5'd31, 10'h3F8, 10'h3FB, 64'h0000_0000_0000_001F};
      vecs[4] = '{0, 2'b01, 5,  5'd31, 10'h008, 10'h00D, 64'h0000_0000_0000_001F};
      vecs[5] = '{1, 2'b11, 0,  5'd0,  10'h000, 10'h000, 64'h0807_0605_0403_0201};
      vecs[6] = '{0, 2'b11, 1,  5'd24, 10'h010, 10'h011, 64'h1F1E_1D1C_1B1A_1918};
      vecs[7] = '{1, 2'b01, 4,  5'd16, 10'h020, 10'h024, 64'h0000_0000_0000_1211};

      idle_inputs();
      bus.wb_ready = 1'b0;
      rst_n = 1'b0;
      #12;
      check("reset_rsp_ready", 64'(bus.rsp_ready), 64'd1);
      check("reset_wb_valid",  64'(bus.wb_valid),  64'd0);
      check("reset_wb_last",   64'(bus.wb_last),   64'd0);
      check("reset_wb_tid",    64'(bus.wb_tid),    64'd0);
      check("reset_wb_data",   bus.wb_data,        64'd0);
      check("reset_busy",      64'(busy),          64'd0);
      do_reset();

      // Table: one-thread responses, each checked then retired.
      for (int v = 0; v < 8; v++) begin
         r.blk  = 4'(v + 3);
         r.base = vecs[v].base;
         r.pend = 8'(1 << vecs[v].bit_i);
         r.size = vecs[v].size;
         r.dst  = 7'(v * 9 + 1);
         r.line = mk_line(vecs[v].plus_one);
         r.amap = set_map('0, vecs[v].bit_i, vecs[v].off);
         send_rsp(r);
         @(negedge clk);
         check($sformatf("vec%0d_tid", v),  64'(bus.wb_tid), 64'(vecs[v].exp_tid));
         check($sformatf("vec%0d_data", v), bus.wb_data, vecs[v].exp_data);
         check($sformatf("vec%0d_last", v), 64'(bus.wb_last), 64'd1);
         check($sformatf("vec%0d_blk", v),  64'(bus.wb_block_id), 64'(v + 3));
         check($sformatf("vec%0d_dst", v),  64'(bus.wb_dest_reg), 64'(v * 9 + 1));
         bus.wb_ready = 1'b1;
         @(posedge clk);
         #1;
         bus.wb_ready = 1'b0;
         @(negedge clk);
         check($sformatf("vec%0d_busy_after", v), 64'(busy), 64'd0);
         @(posedge clk);
         #1;
      end

      // Single two-thread response, consumer always ready.
      r.blk = 4'h5; r.base = 10'h040; r.pend = 8'b0000_0101; r.size = 2'b10; r.dst = 7'h11;
      r.line = mk_line(0);
      r.amap = set_map(set_map('0, 0, 5'd4), 2, 5'd8);
      bus.wb_ready = 1'b1;
      send_rsp(r);
      @(negedge clk);
      check("single_b1_tid",  64'(bus.wb_tid),  64'h040);
      check("single_b1_data", bus.wb_data,      64'h0706_0504);
      check("single_b1_last", 64'(bus.wb_last), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("single_b2_tid",  64'(bus.wb_tid),  64'h042);
      check("single_b2_data", bus.wb_data,      64'h0B0A_0908);
      check("single_b2_last", 64'(bus.wb_last), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("single_busy_after", 64'(busy), 64'd0);
      @(posedge clk); #1;

      // Same response with three stalled cycles.
      bus.wb_ready = 1'b0;
      send_rsp(r);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("bp_hold_valid", 64'(bus.wb_valid), 64'd1);
         check("bp_hold_tid",   64'(bus.wb_tid),   64'h040);
         check("bp_hold_data",  bus.wb_data,       64'h0706_0504);
      end
      bus.wb_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_b2_tid", 64'(bus.wb_tid), 64'h042);
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_done_valid", 64'(bus.wb_valid), 64'd0);
      @(posedge clk); #1;

      // Full FIFO: three full-bitmap responses while the consumer stalls.
      bus.wb_ready = 1'b0;
      r.pend = 8'hFF; r.size = 2'b00; r.amap = '0;
      for (int k = 0; k < 3; k++) begin
         r.base = 10'(k * 8);
         set_rsp(r);
         bus.rsp_valid = 1'b1;
         @(negedge clk);
         check($sformatf("full_ready%0d", k), 64'(bus.rsp_ready), (k < 2) ? 64'd1 : 64'd0);
         if (k < 2) begin
            @(posedge clk); #1;
         end
      end
      bus.wb_ready = 1'b1;
      for (int b = 0; b < 24; b++) begin
         if (b > 0) @(negedge clk);
         check("full_beat_valid", 64'(bus.wb_valid), 64'd1);
         check($sformatf("full_beat%0d_tid", b), 64'(bus.wb_tid), 64'(b));
         check($sformatf("full_beat%0d_ready", b), 64'(bus.rsp_ready),
               (b == 8 || b >= 16) ? 64'd1 : 64'd0);
         @(posedge clk); #1;
         if (b == 8) bus.rsp_valid = 1'b0;
      end
      @(negedge clk);
      check("full_drained", 64'(bus.wb_valid), 64'd0);
      @(posedge clk); #1;

      // Empty bitmap is swallowed.
      r.pend = 8'h00;
      set_rsp(r);
      bus.rsp_valid = 1'b1;
      @(negedge clk);
      check("empty_ready", 64'(bus.rsp_ready), 64'd1);
      @(posedge clk); #1;
      bus.rsp_valid = 1'b0;
      @(negedge clk);
      check("empty_no_wb", 64'(bus.wb_valid), 64'd0);
      check("empty_busy",  64'(busy),         64'd0);
      @(posedge clk); #1;

      // Asynchronous reset during beat 3 of an eight-thread response.
      r.pend = 8'hFF; r.base = 10'h200;
      bus.wb_ready = 1'b1;
      send_rsp(r);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("arst_beat3_tid", 64'(bus.wb_tid), 64'h202);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_wb_valid",  64'(bus.wb_valid),  64'd0);
      check("arst_busy",      64'(busy),          64'd0);
      check("arst_wb_tid",    64'(bus.wb_tid),    64'd0);
      check("arst_rsp_ready", 64'(bus.rsp_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      bus.wb_ready = 1'b0;
      @(posedge clk); #1;
      r.base = 10'h080; r.pend = 8'b0000_0011; r.size = 2'b01;
      r.line = mk_line(1); r.amap = set_map(set_map('0, 0, 5'd2), 1, 5'd6);
      send_rsp(r);
      @(negedge clk);
      check("post_arst_tid0",  64'(bus.wb_tid),  64'h080);
      check("post_arst_data0", bus.wb_data,      64'h0403);
      bus.wb_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("post_arst_tid1",  64'(bus.wb_tid),  64'h081);
      check("post_arst_data1", bus.wb_data,      64'h0807);
      check("post_arst_last1", 64'(bus.wb_last), 64'd1);
      @(posedge clk); #1;

      // Randomized traffic against the queue model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         bm = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         r.blk  = 4'($urandom);
         r.base = 10'($urandom) & 10'h3F8;
         r.pend = bm;
         r.size = 2'($urandom_range(0, 3));
         r.dst  = 7'($urandom);
         for (int w = 0; w < 8; w++) r.line[w*32 +: 32] = $urandom;
         r.amap = {8'($urandom), $urandom};
         set_rsp(r);
         bus.rsp_valid = ($urandom_range(0, 9) < 6);
         bus.wb_ready  = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         exp_ready = (mq.size() < 2);
         exp_valid = (mq.size() != 0);
         check("rnd_rsp_ready", 64'(bus.rsp_ready), 64'(exp_ready));
         check("rnd_wb_valid",  64'(bus.wb_valid),  64'(exp_valid));
         check("rnd_busy",      64'(busy),          64'(exp_valid));
         if (exp_valid) begin
            exp_beat(mq[0], etid, edata, elast);
            check("rnd_wb_tid",  64'(bus.wb_tid),      64'(etid));
            check("rnd_wb_data", bus.wb_data,          edata);
            check("rnd_wb_last", 64'(bus.wb_last),     64'(elast));
            check("rnd_wb_blk",  64'(bus.wb_block_id), 64'(mq[0].blk));
            check("rnd_wb_dst",  64'(bus.wb_dest_reg), 64'(mq[0].dst));
         end else begin
            check("rnd_idle_data", bus.wb_data, 64'd0);
         end
         acc = bus.rsp_valid && exp_ready;
         ret = exp_valid && bus.wb_ready;
         @(posedge clk);
         if (ret) begin
            mq[0].pend = mq[0].pend & (mq[0].pend - 8'd1);
            if (mq[0].pend == 8'h00) void'(mq.pop_front());
         end
         if (acc && r.pend != 8'h00) mq.push_back(r);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
